// File: rtl/pwm_regbank_pkg.sv
// Shared constants for the PWM register bank: register addresses and reset values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pwm_regbank_pkg;

   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_PRESCALE = 8'h01;
   localparam logic [7:0] ADDR_PERIOD   = 8'h02;
   localparam logic [7:0] ADDR_DUTY0    = 8'h03;

   localparam logic [7:0] PRESCALE_RST  = 8'h00;
   localparam logic [7:0] PERIOD_RST    = 8'hFF;
   localparam logic [7:0] DUTY_RST      = 8'h00;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal entering the clk domain.
// Latency: 2 clk edges from a stable input to q.
// Backpressure: none; level passes straight through.
// Ports: clk, rst_n (async active-low, clears to 0), d (async level in), q (synchronized out).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_regbank.sv
// SPI-fed register bank with NUM_CH PWM outputs (prescaler, shared period, per-channel duty).
// Latency: write lands 3-4 clk edges after wr_en_i rises; pwm_o one clk behind the counters.
// Backpressure: none; one write per wr_en_i high pulse, reads are combinational.
// Ports: clk, rst_n; addr_i/data_wr_i/wr_en_i from SPI slave (SCLK domain);
//        data_rd_o combinational read data; pwm_o registered PWM outputs.
module pwm_regbank
   import pwm_regbank_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        addr_i,
   input  logic [7:0]        data_wr_i,
   input  logic              wr_en_i,
   output logic [7:0]        data_rd_o,
   output logic [NUM_CH-1:0] pwm_o
);

   // ---------------- write strobe CDC ----------------
   logic wr_sync2;
   logic wr_sync3;
   logic wr_stb;

   sync_2ff u_wr_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (wr_en_i),
      .q     (wr_sync2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_sync3 <= 1'b0;
      else        wr_sync3 <= wr_sync2;
   end

   // Rising edge only: a long wr_en_i level still commits a single write.
   // addr_i/data_wr_i are held stable by the SPI side while wr_en_i is high.
   assign wr_stb = wr_sync2 & ~wr_sync3;

   // ---------------- shared registers ----------------
   logic [NUM_CH-1:0] ctrl;
   logic [7:0]        prescale;
   logic [7:0]        period;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl     <= '0;
         prescale <= PRESCALE_RST;
         period   <= PERIOD_RST;
      end else if (wr_stb) begin
         if (addr_i == ADDR_CTRL)     ctrl     <= data_wr_i[NUM_CH-1:0];
         if (addr_i == ADDR_PRESCALE) prescale <= data_wr_i;
         if (addr_i == ADDR_PERIOD)   period   <= data_wr_i;
      end
   end

   // ---------------- prescaler and period counter ----------------
   logic [7:0] pre_cnt;
   logic [7:0] per_cnt;
   logic       tick;
   logic       period_end;

   assign tick       = (pre_cnt == prescale);
   assign period_end = tick && (per_cnt == period);

   // If PERIOD/PRESCALE drop below the running count, the counters simply
   // run on through the 8-bit wrap and then resume against the new limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= 8'h00;
         per_cnt <= 8'h00;
      end else begin
         pre_cnt <= tick ? 8'h00 : pre_cnt + 8'd1;
         if (tick) per_cnt <= period_end ? 8'h00 : per_cnt + 8'd1;
      end
   end

   // ---------------- per-channel duty, shadow and compare ----------------
   logic [NUM_CH-1:0][7:0] duty_all;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [7:0] ADDR_MINE = ADDR_DUTY0 + 8'(i);

      logic [7:0] duty_q;
      logic [7:0] shadow_q;
      logic       pwm_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty_q   <= DUTY_RST;
            shadow_q <= DUTY_RST;
            pwm_q    <= 1'b0;
         end else begin
            if (wr_stb && addr_i == ADDR_MINE) duty_q <= data_wr_i;
            // Shadow follows DUTY while disabled so enabling starts clean;
            // when enabled it only reloads at period end, which keeps the
            // running period glitch-free. A write landing on the same edge
            // is not seen until the next boundary.
            if (!ctrl[i] || period_end) shadow_q <= duty_q;
            pwm_q <= ctrl[i] & (per_cnt < shadow_q);
         end
      end

      assign duty_all[i] = duty_q;
      assign pwm_o[i]    = pwm_q;
   end

   // ---------------- read mux ----------------
   always_comb begin
      data_rd_o = 8'h00;
      if (addr_i == ADDR_CTRL) begin
         data_rd_o = 8'(ctrl);
      end else if (addr_i == ADDR_PRESCALE) begin
         data_rd_o = prescale;
      end else if (addr_i == ADDR_PERIOD) begin
         data_rd_o = period;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (addr_i == ADDR_DUTY0 + 8'(c)) data_rd_o = duty_all[c];
         end
      end
   end

endmodule

// File: tb/tb_pwm_regbank.sv
// Self-checking bench for pwm_regbank: register model for reads, duty-cycle
// arithmetic for PWM windows, run-length checks for waveform shape.
module tb_pwm_regbank;

   localparam int NUM_CH = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        addr_i = 8'h00;
   logic [7:0]        data_wr_i = 8'h00;
   logic              wr_en_i = 1'b0;
   logic [7:0]        data_rd_o;
   logic [NUM_CH-1:0] pwm_o;

   int checks = 0;
   int failures = 0;

   logic [7:0]        model [0:127];
   logic [NUM_CH-1:0] hist [$];

   pwm_regbank #(.NUM_CH(NUM_CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr_i    (addr_i),
      .data_wr_i (data_wr_i),
      .wr_en_i   (wr_en_i),
      .data_rd_o (data_rd_o),
      .pwm_o     (pwm_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int a = 0; a < 128; a++) model[a] = 8'h00;
      model[2] = 8'hFF;
   endtask

   task automatic model_write(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] mask;
      mask = 8'((1 << NUM_CH) - 1);
      if (a == 8'h00)              model[0] = d & mask;
      else if (a < 8'(3 + NUM_CH)) model[a[6:0]] = d;
   endtask

   // ---------------- bus helpers ----------------
   task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr_i = a;
      data_wr_i = d;
      wr_en_i = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      wr_en_i = 1'b0;
      repeat (3) @(posedge clk);
      model_write(a, d);
   endtask

   task automatic check_read(input logic [7:0] a, input string name);
      @(negedge clk);
      addr_i = a;
      #1;
      checks++;
      if (data_rd_o !== model[a[6:0]]) begin
         failures++;
         $display("FAIL %s addr=%02h got=%02h exp=%02h", name, a, data_rd_o, model[a[6:0]]);
      end
   endtask

   task automatic check_all_reads(input string name);
      for (int a = 0; a < 3 + NUM_CH + 1; a++) check_read(8'(a), name);
      check_read(8'h7F, name);
   endtask

   // Call right after a negedge: hist[0] is the current value, then n more samples.
   task automatic record(input int n);
      hist.delete();
      hist.push_back(pwm_o);
      repeat (n) begin
         @(negedge clk);
         hist.push_back(pwm_o);
      end
   endtask

   function automatic int find_rise(input int ch, input int from);
      for (int i = (from < 1 ? 1 : from); i < hist.size(); i++)
         if (hist[i][ch] && !hist[i-1][ch]) return i;
      return -1;
   endfunction

   function automatic int run_len(input int ch, input int idx, input logic val);
      int n = 0;
      for (int i = idx; i < hist.size(); i++) begin
         if (hist[i][ch] !== val) break;
         n++;
      end
      return n;
   endfunction

   function automatic int count_high(input int ch, input int from, input int len);
      int n = 0;
      for (int i = from; i < from + len && i < hist.size(); i++)
         if (hist[i][ch]) n++;
      return n;
   endfunction

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Checks hi/lo/hi run lengths following the first rising edge in hist.
   task automatic check_shape(input string name, input int ch, input int h1, input int l1, input int h2);
      int r, h, l;
      r = find_rise(ch, 0);
      checks++;
      if (r < 0) begin
         failures++;
         $display("FAIL %s no rising edge on pwm_o[%0d]", name, ch);
      end else begin
         h = run_len(ch, r, 1'b1);
         l = run_len(ch, r + h, 1'b0);
         check_int({name, "_hi1"}, h, h1);
         check_int({name, "_lo1"}, l, l1);
         check_int({name, "_hi2"}, run_len(ch, r + h + l, 1'b1), h2);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (pwm_o !== '0) begin
         failures++;
         $display("FAIL reset_pwm got=%b exp=0", pwm_o);
      end
      check_all_reads("reset_read");
   endtask

   task automatic test_write_read();
      @(negedge clk);
      addr_i = 8'h03;
      data_wr_i = 8'h40;
      wr_en_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (data_rd_o !== 8'h00) begin
         failures++;
         $display("FAIL wr_too_early got=%02h exp=00", data_rd_o);
      end
      // The synchronizer may take up to four edges to deliver the write.
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (data_rd_o !== 8'h40) begin
         failures++;
         $display("FAIL wr_latency got=%02h exp=40", data_rd_o);
      end
      repeat (2) @(posedge clk);
      // Data changes while the level stays high: no second write may happen.
      @(negedge clk);
      data_wr_i = 8'h55;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (data_rd_o !== 8'h40) begin
         failures++;
         $display("FAIL wr_single got=%02h exp=40", data_rd_o);
      end
      @(negedge clk);
      wr_en_i = 1'b0;
      repeat (3) @(posedge clk);
      model_write(8'h03, 8'h40);
      check_read(8'h03, "wr_readback");
   endtask

   task automatic test_pwm_ratio();
      write_reg(8'h01, 8'h00);
      write_reg(8'h02, 8'd9);
      write_reg(8'h03, 8'd3);
      write_reg(8'h00, 8'h01);
      repeat (300) @(posedge clk);
      @(negedge clk);
      record(60);
      check_shape("ratio", 0, 3, 7, 3);
      check_int("ratio_window", count_high(0, 1, 10), 3);
   endtask

   task automatic test_boundaries();
      write_reg(8'h04, 8'h00);
      write_reg(8'h00, 8'h03);
      repeat (30) @(posedge clk);
      @(negedge clk);
      record(40);
      check_int("duty_zero", count_high(1, 1, 40), 0);
      write_reg(8'h04, 8'h20);
      repeat (30) @(posedge clk);
      @(negedge clk);
      record(40);
      check_int("duty_over_period", count_high(1, 1, 40), 40);
      write_reg(8'h7F, 8'hAA);
      check_all_reads("unmapped_write");
   endtask

   task automatic test_glitch_free();
      logic prev;
      @(negedge clk);
      fork
         record(40);
         begin
            prev = pwm_o[0];
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               if (pwm_o[0] && !prev) break;
               prev = pwm_o[0];
            end
            write_reg(8'h03, 8'd7);
         end
      join
      check_shape("glitch", 0, 3, 7, 7);
   endtask

   task automatic test_prescaler();
      write_reg(8'h01, 8'd3);
      write_reg(8'h02, 8'd1);
      write_reg(8'h03, 8'd1);
      write_reg(8'h00, 8'h01);
      repeat (1100) @(posedge clk);
      @(negedge clk);
      record(40);
      check_shape("prescale", 0, 4, 4, 4);
   endtask

   task automatic test_random();
      int pre, per, w, exp;
      logic [7:0] duty [NUM_CH];
      logic [7:0] en;
      for (int it = 0; it < 5; it++) begin
         pre = $urandom_range(0, 2);
         per = $urandom_range(1, 15);
         en  = 8'($urandom_range(0, 255));
         w   = (per + 1) * (pre + 1);
         write_reg(8'h02, 8'(per));
         write_reg(8'h01, 8'(pre));
         for (int c = 0; c < NUM_CH; c++) begin
            duty[c] = 8'($urandom_range(0, 20));
            write_reg(8'(3 + c), duty[c]);
         end
         write_reg(8'h00, en);
         repeat (260 * (pre + 1) + 2 * w + 10) @(posedge clk);
         @(negedge clk);
         record(w);
         for (int c = 0; c < NUM_CH; c++) begin
            if (!en[c])                exp = 0;
            else if (int'(duty[c]) > per) exp = w;
            else                       exp = int'(duty[c]) * (pre + 1);
            check_int($sformatf("rand%0d_ch%0d", it, c), count_high(c, 1, w), exp);
         end
         check_all_reads($sformatf("rand%0d_read", it));
      end
   endtask

   task automatic test_reset_mid();
      write_reg(8'h01, 8'h00);
      write_reg(8'h02, 8'd9);
      write_reg(8'h03, 8'h20);
      write_reg(8'h00, 8'h01);
      repeat (300) @(posedge clk);
      @(negedge clk);
      checks++;
      if (pwm_o[0] !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_pre got=%b exp=1", pwm_o[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_o !== '0) begin
         failures++;
         $display("FAIL mid_reset_async got=%b exp=0", pwm_o);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_read(8'h02, "mid_reset_period");
      check_read(8'h00, "mid_reset_ctrl");
      check_read(8'h03, "mid_reset_duty0");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_pwm_ratio();
      test_boundaries();
      test_glitch_free();
      test_prescaler();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
